// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared definitions for the completion-side CDB arbiter: default widths,
//   the reserved "no destination" physical register, functional-unit port
//   indices and the broadcast packet layout seen by rs_bank, PRF and ROB.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU         = 4;
  localparam int CDB_FIFO_DEPTH     = 2;
  localparam int CDB_SCALAR_WIDTH   = 2;
  localparam int CDB_PREG_IDX_WIDTH = 6;
  localparam int CDB_XLEN           = 32;

  // Physical register 0 is the hard-wired x0 destination; results aimed at it
  // (x0 writes, stores, branches) carry no information worth broadcasting.
  localparam logic [CDB_PREG_IDX_WIDTH-1:0] ZERO_PREG = '0;

  // Completion port index of each functional unit.
  typedef enum logic [1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MULT = 2'd2,
    FU_LSQ  = 2'd3
  } fu_idx_e;

  typedef struct packed {
    logic                          valid;
    logic [CDB_PREG_IDX_WIDTH-1:0] tag;
    logic [CDB_XLEN-1:0]           value;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_fifo
//   Small completion buffer for one functional unit. Head entry is read
//   combinationally so the arbiter can broadcast it in the same cycle it pops.
//   Pushes into a full buffer are ignored; clear empties the buffer and
//   overrides any push or pop in the same cycle.
// Ports
//   clock        in  rising-edge clock
//   reset        in  synchronous, active-high
//   clear_i      in  discard all entries at this edge
//   push_i       in  write push_data_i at the tail (ignored when full)
//   pop_i        in  retire the head entry (ignored when empty)
//   push_data_i  in  entry to write
//   head_o       out oldest entry (meaningful only when !empty_o)
//   full_o       out buffer holds DEPTH entries
//   empty_o      out buffer holds no entries
// -----------------------------------------------------------------------------
module cdb_arbiter_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  // NOTE: every variable gets its default before any branch, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; an entry is
  // only ever read while count_q says it holds valid data.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Collects completed results from the functional units (ALU0, ALU1, MULT,
//   LSQ), buffers them per unit and broadcasts up to SCALAR_WIDTH of them per
//   cycle on the CDB with round-robin fairness. Broadcasts are always
//   accepted downstream, so every granted head pops at the same edge.
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high; dominates squash
//   squash         in   mispredict flush: drop all buffered results and any
//                       push arriving in the same cycle
//   fu_done_valid  in   [NUM_FU]            unit i presents a result
//   fu_done_tag    in   [NUM_FU*PREG]       destination preg per unit
//   fu_done_value  in   [NUM_FU*XLEN]       result data per unit
//   fu_stall       out  [NUM_FU]            unit i buffer full, unit must hold
//   cdb_valid      out  [SCALAR_WIDTH]      lane k carries a broadcast
//   cdb_tag        out  [SCALAR_WIDTH*PREG] broadcast tag (ZERO_PREG if idle)
//   cdb_value      out  [SCALAR_WIDTH*XLEN] broadcast value (0 if idle)
// All outputs depend on registered state only.
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU         = CDB_NUM_FU,
  parameter int FIFO_DEPTH     = CDB_FIFO_DEPTH,
  parameter int SCALAR_WIDTH   = CDB_SCALAR_WIDTH,
  parameter int PREG_IDX_WIDTH = CDB_PREG_IDX_WIDTH,
  parameter int XLEN           = CDB_XLEN
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_done_valid,
  input  logic [NUM_FU*PREG_IDX_WIDTH-1:0] fu_done_tag,
  input  logic [NUM_FU*XLEN-1:0]           fu_done_value,
  output logic [NUM_FU-1:0]                fu_stall,
  output logic [SCALAR_WIDTH-1:0]          cdb_valid,
  output logic [SCALAR_WIDTH*PREG_IDX_WIDTH-1:0] cdb_tag,
  output logic [SCALAR_WIDTH*XLEN-1:0]     cdb_value
);

  localparam int RR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int ENTRY_W = PREG_IDX_WIDTH + XLEN;

  logic [ENTRY_W-1:0]      head [NUM_FU];
  logic [NUM_FU-1:0]       fifo_full;
  logic [NUM_FU-1:0]       fifo_empty;
  logic [NUM_FU-1:0]       push;
  logic [NUM_FU-1:0]       grant;
  logic [NUM_FU-1:0]       req_rot;
  logic [SCALAR_WIDTH-1:0] lane_valid;
  logic [RR_W-1:0]         lane_fu [SCALAR_WIDTH];
  logic [RR_W-1:0]         last_fu;
  logic [RR_W-1:0]         rr_ptr_q, rr_ptr_d;

  // One completion buffer per functional unit. Entries are {tag, value}.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign push[i] = fu_done_valid[i] &&
                     (fu_done_tag[i*PREG_IDX_WIDTH +: PREG_IDX_WIDTH] != ZERO_PREG);

    cdb_arbiter_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .clear_i     (squash),
      .push_i      (push[i]),
      .pop_i       (grant[i]),
      .push_data_i ({fu_done_tag[i*PREG_IDX_WIDTH +: PREG_IDX_WIDTH],
                     fu_done_value[i*XLEN +: XLEN]}),
      .head_o      (head[i]),
      .full_o      (fifo_full[i]),
      .empty_o     (fifo_empty[i])
    );
  end

  assign fu_stall = fifo_full;

  // Rotate the request vector so bit 0 is the unit rr_ptr points at; a plain
  // lowest-index-first pick on the rotated vector is then round-robin order.
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      req_rot[k] = !fifo_empty[RR_W'((int'(rr_ptr_q) + k) % NUM_FU)];
    end
  end

  // Each lane takes the lowest remaining rotated request and removes it, so
  // lane 0 gets the first hit and lane 1 the second.
  always_comb begin
    logic [NUM_FU-1:0] remaining;
    logic              found;
    logic [RR_W-1:0]   sel;
    remaining  = req_rot;
    grant      = '0;
    lane_valid = '0;
    last_fu    = rr_ptr_q;
    for (int l = 0; l < SCALAR_WIDTH; l++) begin
      lane_fu[l] = '0;
      found      = 1'b0;
      sel        = '0;
      for (int k = 0; k < NUM_FU; k++) begin
        if (!found && remaining[k]) begin
          found = 1'b1;
          sel   = RR_W'(k);
        end
      end
      if (found) begin
        remaining[sel]     = 1'b0;
        lane_valid[l]      = 1'b1;
        lane_fu[l]         = RR_W'((int'(sel) + int'(rr_ptr_q)) % NUM_FU);
        grant[lane_fu[l]]  = 1'b1;
        last_fu            = lane_fu[l];
      end
    end
  end

  // The pointer moves just past the last unit served; a squash keeps it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant && !squash) rr_ptr_d = RR_W'((int'(last_fu) + 1) % NUM_FU);
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  // Lane muxes: idle lanes drive ZERO_PREG / 0 so snoopers never see stale data.
  always_comb begin
    cdb_valid = lane_valid;
    cdb_tag   = '0;
    cdb_value = '0;
    for (int l = 0; l < SCALAR_WIDTH; l++) begin
      if (lane_valid[l]) begin
        cdb_tag[l*PREG_IDX_WIDTH +: PREG_IDX_WIDTH] =
          head[lane_fu[l]][ENTRY_W-1 -: PREG_IDX_WIDTH];
        cdb_value[l*XLEN +: XLEN] = head[lane_fu[l]][XLEN-1:0];
      end else begin
        cdb_tag[l*PREG_IDX_WIDTH +: PREG_IDX_WIDTH] = ZERO_PREG;
      end
    end
  end

endmodule
